// File: rtl/bsg_hbm_pkg.sv
// ---------------------------------------------------------------------------
// bsg_hbm_pkg
// Shared types and helpers for the single-channel HBM responder.
//   hbm_req_s             : request descriptor (write_not_read, ch_addr), also
//                           used by the trace-replay benches.
//   hbm_state_e           : responder availability state (IDLE / REFRESH).
//   hbm_byte_offset_width : number of byte-offset address bits in one beat.
// ---------------------------------------------------------------------------
package bsg_hbm_pkg;

    localparam int unsigned hbm_ch_addr_width_gp = 29;

    typedef struct packed {
        logic                            write_not_read;
        logic [hbm_ch_addr_width_gp-1:0] ch_addr;
    } hbm_req_s;

    typedef enum logic {
        e_hbm_idle    = 1'b0,
        e_hbm_refresh = 1'b1
    } hbm_state_e;

    function automatic int unsigned hbm_byte_offset_width(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/bsg_hbm_refresh_fsm.sv
// ---------------------------------------------------------------------------
// bsg_hbm_refresh_fsm
// Tracks the refresh schedule of the channel and gates request acceptance.
//   clk_i       in  clock
//   reset_n_i   in  asynchronous active-low reset
//   i_accepted  in  a request was consumed this cycle (defers a due refresh)
//   o_accept_en out 1 while IDLE; 0 for the whole refresh blackout
// A refresh_interval_p of 0 keeps the channel permanently IDLE.
// ---------------------------------------------------------------------------
module bsg_hbm_refresh_fsm
    import bsg_hbm_pkg::*;
#(
    parameter int unsigned refresh_interval_p = 256,
    parameter int unsigned refresh_cycles_p   = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic i_accepted,
    output logic o_accept_en
);

    // +2 keeps the width at least one bit even when refresh is disabled.
    localparam int unsigned interval_cnt_width_lp = $clog2(refresh_interval_p + 2);
    localparam int unsigned blackout_cnt_width_lp = $clog2(refresh_cycles_p + 2);

    localparam logic [interval_cnt_width_lp-1:0] interval_last_lp =
        interval_cnt_width_lp'((refresh_interval_p == 0) ? 0 : refresh_interval_p - 1);
    localparam logic [blackout_cnt_width_lp-1:0] blackout_last_lp =
        blackout_cnt_width_lp'(refresh_cycles_p - 1);

    hbm_state_e                        r_state;
    logic [interval_cnt_width_lp-1:0]  r_interval_cnt;
    logic [blackout_cnt_width_lp-1:0]  r_blackout_cnt;
    logic                              r_accept_en;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= e_hbm_idle;
            r_interval_cnt <= '0;
            r_blackout_cnt <= '0;
            r_accept_en    <= 1'b1;
        end else begin
            case (r_state)
                e_hbm_idle: begin
                    if (refresh_interval_p != 0) begin
                        if (r_interval_cnt == interval_last_lp) begin
                            // Counter holds at its last value while traffic
                            // keeps the refresh deferred.
                            if (!i_accepted) begin
                                r_state        <= e_hbm_refresh;
                                r_interval_cnt <= '0;
                                r_accept_en    <= 1'b0;
                            end
                        end else begin
                            r_interval_cnt <= r_interval_cnt + interval_cnt_width_lp'(1);
                        end
                    end
                end
                e_hbm_refresh: begin
                    if (r_blackout_cnt == blackout_last_lp) begin
                        r_state        <= e_hbm_idle;
                        r_blackout_cnt <= '0;
                        r_accept_en    <= 1'b1;
                    end else begin
                        r_blackout_cnt <= r_blackout_cnt + blackout_cnt_width_lp'(1);
                    end
                end
                default: begin
                    r_state     <= e_hbm_idle;
                    r_accept_en <= 1'b1;
                end
            endcase
        end
    end

    assign o_accept_en = r_accept_en;

endmodule

// File: rtl/bsg_hbm_channel_responder.sv
// ---------------------------------------------------------------------------
// bsg_hbm_channel_responder
// Deterministic memory side of one HBM channel: byte-masked writes into a
// small backing store, fixed-latency in-order read returns, periodic refresh
// blackouts.
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   v_i, write_not_read_i    request valid / direction
//   ch_addr_i                byte address (upper bits alias, offset ignored)
//   yumi_o                   request consumed this cycle (combinational)
//   data_v_i, data_i         write data valid / beat
//   data_mask_i              per-byte write enables
//   data_yumi_o              write data consumed this cycle (combinational)
//   data_v_o, data_o         read return pulse / beat
//   read_done_ch_addr_o      address of the returned read
// ---------------------------------------------------------------------------
module bsg_hbm_channel_responder
    import bsg_hbm_pkg::*;
#(
    parameter int unsigned channel_addr_width_p = 29,
    parameter int unsigned data_width_p         = 512,
    parameter int unsigned mem_els_p            = 64,
    parameter int unsigned read_latency_p       = 4,
    parameter int unsigned refresh_interval_p   = 256,
    parameter int unsigned refresh_cycles_p     = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            v_i,
    input  logic                            write_not_read_i,
    input  logic [channel_addr_width_p-1:0] ch_addr_i,
    output logic                            yumi_o,
    input  logic                            data_v_i,
    input  logic [data_width_p-1:0]         data_i,
    input  logic [data_width_p/8-1:0]       data_mask_i,
    output logic                            data_yumi_o,
    output logic                            data_v_o,
    output logic [data_width_p-1:0]         data_o,
    output logic [channel_addr_width_p-1:0] read_done_ch_addr_o
);

    localparam int unsigned mask_width_lp   = data_width_p / 8;
    localparam int unsigned offset_width_lp = hbm_byte_offset_width(data_width_p);
    localparam int unsigned index_width_lp  = $clog2(mem_els_p);

    logic                            w_accept_en;
    logic                            w_read_accept;
    logic                            w_write_accept;
    logic [index_width_lp-1:0]       w_index;

    logic [data_width_p-1:0]         r_mem       [mem_els_p];
    logic                            r_pipe_v    [read_latency_p];
    logic [channel_addr_width_p-1:0] r_pipe_addr [read_latency_p];
    logic [data_width_p-1:0]         r_pipe_data [read_latency_p];

    bsg_hbm_refresh_fsm #(
        .refresh_interval_p (refresh_interval_p),
        .refresh_cycles_p   (refresh_cycles_p)
    ) u_refresh_fsm (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .i_accepted  (yumi_o),
        .o_accept_en (w_accept_en)
    );

    always_comb begin
        w_index        = ch_addr_i[offset_width_lp +: index_width_lp];
        w_read_accept  = w_accept_en & v_i & ~write_not_read_i;
        w_write_accept = w_accept_en & v_i & write_not_read_i & data_v_i;
    end

    assign yumi_o      = w_read_accept | w_write_accept;
    assign data_yumi_o = w_write_accept;

    // Backing store is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_write_accept) begin
            for (int unsigned b = 0; b < mask_width_lp; b++) begin
                if (data_mask_i[b]) begin
                    r_mem[w_index][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures memory in the acceptance cycle; since the store is
    // read asynchronously, a write from the previous edge is already visible.
    // Empty stages carry zeros so the outputs are quiet between returns.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned s = 0; s < read_latency_p; s++) begin
                r_pipe_v[s]    <= 1'b0;
                r_pipe_addr[s] <= '0;
                r_pipe_data[s] <= '0;
            end
        end else begin
            r_pipe_v[0]    <= w_read_accept;
            r_pipe_addr[0] <= w_read_accept ? ch_addr_i : '0;
            r_pipe_data[0] <= w_read_accept ? r_mem[w_index] : '0;
            for (int unsigned s = 1; s < read_latency_p; s++) begin
                r_pipe_v[s]    <= r_pipe_v[s-1];
                r_pipe_addr[s] <= r_pipe_addr[s-1];
                r_pipe_data[s] <= r_pipe_data[s-1];
            end
        end
    end

    assign data_v_o            = r_pipe_v[read_latency_p-1];
    assign data_o              = r_pipe_data[read_latency_p-1];
    assign read_done_ch_addr_o = r_pipe_addr[read_latency_p-1];

endmodule

// File: tb/tb_bsg_hbm_channel_responder.sv
// ---------------------------------------------------------------------------
// tb_bsg_hbm_channel_responder
// Directed bench. Instance dut uses default parameters for the data path;
// instance dut_r uses a short refresh schedule (16 / 4) for blackout timing.
// Inputs are driven on the falling edge and outputs sampled #1 later.
// ---------------------------------------------------------------------------
module tb_bsg_hbm_channel_responder;

    localparam int unsigned AW = 29;
    localparam int unsigned DW = 512;
    localparam int unsigned MW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main instance
    logic          rst_n;
    logic          v, wnr, dv_in;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [MW-1:0] dmask;
    logic          yumi, dyumi, dv_out;
    logic [DW-1:0] dout;
    logic [AW-1:0] rdaddr;

    // refresh instance
    logic          rst_b, v_b;
    logic [AW-1:0] addr_b;
    logic          yumi_b, dyumi_b, dvo_b;
    logic [DW-1:0] dout_b;
    logic [AW-1:0] rda_b;

    bsg_hbm_channel_responder dut (
        .clk_i               (clk),
        .reset_n_i           (rst_n),
        .v_i                 (v),
        .write_not_read_i    (wnr),
        .ch_addr_i           (addr),
        .yumi_o              (yumi),
        .data_v_i            (dv_in),
        .data_i              (din),
        .data_mask_i         (dmask),
        .data_yumi_o         (dyumi),
        .data_v_o            (dv_out),
        .data_o              (dout),
        .read_done_ch_addr_o (rdaddr)
    );

    bsg_hbm_channel_responder #(
        .refresh_interval_p (16),
        .refresh_cycles_p   (4)
    ) dut_r (
        .clk_i               (clk),
        .reset_n_i           (rst_b),
        .v_i                 (v_b),
        .write_not_read_i    (1'b0),
        .ch_addr_i           (addr_b),
        .yumi_o              (yumi_b),
        .data_v_i            (1'b0),
        .data_i              ({DW{1'b0}}),
        .data_mask_i         ({MW{1'b0}}),
        .data_yumi_o         (dyumi_b),
        .data_v_o            (dvo_b),
        .data_o              (dout_b),
        .read_done_ch_addr_o (rda_b)
    );

    function automatic logic [DW-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'h10 + 8'(i);
        return {MW{b}};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            v = 1'b0; wnr = 1'b0; dv_in = 1'b0;
        end
    endtask

    // Leaves the request driven; the write lands on the next rising edge.
    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [MW-1:0] m, output bit ok);
        int n;
        @(negedge clk);
        v = 1'b1; wnr = 1'b1; addr = a; dv_in = 1'b1; din = d; dmask = m;
        #1;
        n = 0;
        while (!dyumi && n < 64) begin
            @(negedge clk); #1; n++;
        end
        ok = dyumi;
    endtask

    // lat = cycles from the accepting cycle to the data_v_o cycle.
    task automatic issue_read(input logic [AW-1:0] a, output int lat,
                              output logic [DW-1:0] d, output logic [AW-1:0] ra,
                              output bit timed_out);
        int n;
        @(negedge clk);
        v = 1'b1; wnr = 1'b0; addr = a; dv_in = 1'b0;
        #1;
        n = 0;
        while (!yumi && n < 64) begin
            @(negedge clk); #1; n++;
        end
        lat = 0; d = '0; ra = '0;
        timed_out = !yumi;
        if (!timed_out) begin
            @(negedge clk);
            v = 1'b0;
            lat = 1;
            while (!dv_out && lat < 20) begin
                @(negedge clk); lat++;
            end
            timed_out = !dv_out;
            d = dout; ra = rdaddr;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL reset_data_v: got %b want 0", dv_out); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_data_o: got %h want 0", dout); end
        checks++; if (rdaddr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", rdaddr); end
        checks++; if (yumi !== 1'b0 || dyumi !== 1'b0) begin errors++; $display("FAIL reset_yumi: got %b%b want 00", yumi, dyumi); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_data_valid_stall;
        int lat; logic [DW-1:0] d; logic [AW-1:0] ra; bit to;
        @(negedge clk);
        v = 1'b0; dv_in = 1'b1; din = {MW{8'h3C}}; dmask = '1; #1;
        checks++; if (dyumi !== 1'b0) begin errors++; $display("FAIL orphan_data: data_yumi got %b want 0", dyumi); end
        @(negedge clk);
        v = 1'b1; wnr = 1'b1; addr = 29'h200; dv_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (yumi !== 1'b0 || dyumi !== 1'b0) begin errors++; $display("FAIL stall_%0d: yumi/data_yumi got %b%b want 00", i, yumi, dyumi); end
            @(negedge clk);
        end
        dv_in = 1'b1; #1;
        checks++; if (yumi !== 1'b1 || dyumi !== 1'b1) begin errors++; $display("FAIL stall_release: yumi/data_yumi got %b%b want 11", yumi, dyumi); end
        idle(1);
        issue_read(29'h200, lat, d, ra, to);
        checks++; if (to || d !== {MW{8'h3C}}) begin errors++; $display("FAIL stall_readback: got %h want %h", d, {MW{8'h3C}}); end
    endtask

    task automatic test_write_read;
        int lat; logic [DW-1:0] d; logic [AW-1:0] ra; bit to; bit ok;
        issue_write(29'h40, {MW{8'hA5}}, '1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_accept: timed out want data_yumi 1"); end
        idle(1);
        issue_read(29'h40, lat, d, ra, to);
        checks++; if (to || lat != 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
        checks++; if (d !== {MW{8'hA5}}) begin errors++; $display("FAIL rd_data: got %h want %h", d, {MW{8'hA5}}); end
        checks++; if (ra !== 29'h40) begin errors++; $display("FAIL rd_addr: got %h want 40", ra); end
        // index bits are [11:6]; bit 12 and the low offset bits alias onto 0x40
        issue_read(29'h1047, lat, d, ra, to);
        checks++; if (to || d !== {MW{8'hA5}}) begin errors++; $display("FAIL alias_data: got %h want %h", d, {MW{8'hA5}}); end
        checks++; if (ra !== 29'h1047) begin errors++; $display("FAIL alias_addr: got %h want 1047", ra); end
    endtask

    task automatic test_masked_write;
        int lat; logic [DW-1:0] d; logic [AW-1:0] ra; bit to; bit ok;
        logic [DW-1:0] expv;
        expv = '0;
        expv[7:0] = 8'hFF;
        issue_write(29'h80, '0, '1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_clear: timed out want data_yumi 1"); end
        issue_write(29'h80, '1, 64'h1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_write: timed out want data_yumi 1"); end
        idle(1);
        issue_read(29'h80, lat, d, ra, to);
        checks++; if (to || d !== expv) begin errors++; $display("FAIL mask_data: got %h want %h", d, expv); end
    endtask

    task automatic test_write_then_read;
        int lat; logic [DW-1:0] d; logic [AW-1:0] ra; bit to; bit ok;
        issue_write(29'h2C0, {MW{8'h11}}, '1, ok);
        issue_write(29'h2C0, {32{16'hBEEF}}, '1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL raw_write: timed out want data_yumi 1"); end
        issue_read(29'h2C0, lat, d, ra, to);
        checks++; if (to || lat != 4 || d !== {32{16'hBEEF}}) begin errors++; $display("FAIL raw_data: got %h lat %0d want %h lat 4", d, lat, {32{16'hBEEF}}); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            issue_write(29'(32'h100 + 32'(i) * 32'h40), pat(i), '1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_prewrite_%0d: timed out want data_yumi 1", i); end
        end
        idle(1);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            v = (c < 4); wnr = 1'b0; addr = 29'(32'h100 + 32'(c) * 32'h40);
            #1;
            checks++; if (yumi !== (c < 4)) begin errors++; $display("FAIL b2b_yumi_%0d: got %b want %b", c, yumi, (c < 4)); end
            if (c >= 4 && c < 8) begin
                checks++;
                if (dv_out !== 1'b1 || dout !== pat(c - 4) || rdaddr !== 29'(32'h100 + 32'(c - 4) * 32'h40)) begin
                    errors++; $display("FAIL b2b_return_%0d: v %b data %h addr %h want v 1 data %h", c, dv_out, dout, rdaddr, pat(c - 4));
                end
            end else begin
                checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL b2b_quiet_%0d: data_v got %b want 0", c, dv_out); end
            end
        end
        idle(1);
    endtask

    task automatic test_reset_mid_burst;
        int lat; logic [DW-1:0] d; logic [AW-1:0] ra; bit to;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            v = 1'b1; wnr = 1'b0; addr = 29'(32'h100 + 32'(c) * 32'h40);
            #1;
            checks++; if (yumi !== 1'b1) begin errors++; $display("FAIL burst_yumi_%0d: got %b want 1", c, yumi); end
        end
        checks++; if (dv_out !== 1'b1 || dout !== pat(0)) begin errors++; $display("FAIL burst_first_return: v %b data %h want v 1 data %h", dv_out, dout, pat(0)); end
        @(negedge clk);
        rst_n = 1'b0; v = 1'b0;
        #1;
        checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL burst_reset_async: data_v got %b want 0", dv_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL burst_after_reset_%0d: data_v got %b want 0", c, dv_out); end
            @(negedge clk);
        end
        issue_read(29'h140, lat, d, ra, to);
        checks++; if (to || lat != 4 || d !== pat(1)) begin errors++; $display("FAIL post_reset_read: lat %0d data %h want lat 4 data %h", lat, d, pat(1)); end
    endtask

    // Refresh-instance schedule after reset release (cycle 0 ends at the first
    // rising edge): counter reaches 15 on cycle 15, request dropped there, so
    // blackout covers 16..19; again 35 -> 36..39. On cycle 55 the counter is
    // due but reads keep arriving, deferring it until v drops on 58 -> 59..62.
    task automatic test_refresh;
        bit ey [0:70];
        bit vv, blk, exp_dv;
        for (int k = 0; k <= 70; k++) ey[k] = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            vv  = !(k == 15 || k == 35 || k == 58);
            blk = (k >= 16 && k <= 19) || (k >= 36 && k <= 39) || (k >= 59 && k <= 62);
            ey[k] = vv && !blk;
            exp_dv = (k >= 5) && ey[k - 4];
            @(negedge clk);
            v_b = vv; addr_b = 29'(k * 64);
            #1;
            checks++; if (yumi_b !== ey[k]) begin errors++; $display("FAIL refresh_yumi_c%0d: got %b want %b", k, yumi_b, ey[k]); end
            checks++; if (dvo_b !== exp_dv) begin errors++; $display("FAIL refresh_data_v_c%0d: got %b want %b", k, dvo_b, exp_dv); end
            if (exp_dv) begin
                checks++; if (rda_b !== 29'((k - 4) * 64)) begin errors++; $display("FAIL refresh_rd_addr_c%0d: got %h want %h", k, rda_b, 29'((k - 4) * 64)); end
            end
        end
        @(negedge clk);
        v_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; v = 1'b0; wnr = 1'b0; dv_in = 1'b0;
        addr = '0; din = '0; dmask = '0;
        rst_b = 1'b0; v_b = 1'b0; addr_b = '0;
        test_reset;
        test_data_valid_stall;
        test_write_read;
        test_masked_write;
        test_write_then_read;
        test_back_to_back;
        test_reset_mid_burst;
        test_refresh;
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
